// File: rtl/gpio_irq_ctrl.sv
// GPIO edge-interrupt controller: per-pin edge detect, pending latch, in-order serve FSM, overrun count.
// Optional macro GPIO_IRQ_SYNC_EN adds a 2-flop input synchronizer ahead of gpio_q.
//
// state | meaning
// IDLE  | nothing being served; wait for any pending bit
// ARB   | latch lowest-index pending pin into irq_id
// SERVE | maip asserted; wait for matching ack or the pin to be masked off
module gpio_irq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] gpio_in,
  input  logic [7:0] gpio_dir,
  input  logic [7:0] int_en,
  input  logic [7:0] int_pol,
  input  logic       ack_valid,
  input  logic [2:0] ack_id,
  output logic       maip,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic [7:0] overrun_cnt
);

  typedef enum logic [1:0] {IDLE, ARB, SERVE} state_t;

  logic [7:0] gpio_src;

`ifdef GPIO_IRQ_SYNC_EN
  localparam logic [2:0] WARM_CYCLES = 3'd4;

  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  assign gpio_src = sync2_q;
`else
  localparam logic [2:0] WARM_CYCLES = 3'd2;

  assign gpio_src = gpio_in;
`endif

  state_t     state_q, state_d;
  logic [2:0] irq_id_q, irq_id_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] overrun_q, overrun_d;
  logic [7:0] gpio_q, gpio_q_d;
  logic [2:0] warm_q, warm_d;

  logic       warm_done;
  logic       ack_hit;
  logic       lost;
  logic [7:0] ack_mask;
  logic [7:0] allow;
  logic [7:0] evt;
  logic [2:0] arb_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_id_q  <= 3'd0;
      pending_q <= 8'h00;
      overrun_q <= 8'h00;
      gpio_q    <= 8'h00;
      gpio_q_d  <= 8'h00;
      warm_q    <= WARM_CYCLES;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      gpio_q    <= gpio_src;
      gpio_q_d  <= gpio_q;
      warm_q    <= warm_d;
    end
  end

  // Edge detection stays off until the whole sample pipe holds post-reset data.
  assign warm_d    = (warm_q != 3'd0) ? warm_q - 3'd1 : 3'd0;
  assign warm_done = (warm_q == 3'd0);

  assign allow    = ~gpio_dir & int_en;
  assign ack_hit  = (state_q == SERVE) && ack_valid && (ack_id == irq_id_q);
  assign ack_mask = ack_hit ? (8'd1 << irq_id_q) : 8'h00;

  always_comb begin
    evt = 8'h00;
    if (warm_done)
      evt = allow & ((int_pol & gpio_q & ~gpio_q_d) | (~int_pol & ~gpio_q & gpio_q_d));
  end

  // A fresh event wins over a same-cycle ack, so the pin stays pending.
  assign pending_d = ((pending_q & ~ack_mask) | evt) & allow;
  assign lost      = |(evt & pending_q & ~ack_mask);
  assign overrun_d = (lost && (overrun_q != 8'hFF)) ? overrun_q + 8'd1 : overrun_q;

  always_comb begin
    arb_id = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (pending_q[i]) arb_id = 3'(i);
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (pending_q != 8'h00) state_d = ARB;
      end
      ARB: begin
        if (pending_q != 8'h00) begin
          irq_id_d = arb_id;
          state_d  = SERVE;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (ack_hit || !pending_q[irq_id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign maip        = (state_q == SERVE);
  assign irq_id      = irq_id_q;
  assign pending     = pending_q;
  assign overrun_cnt = overrun_q;

endmodule
